mem_port_arbiter: RTL

//  Shares the single-port data RAM between two requesters: instruction fetch (I) and load/store (D).

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_starve_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

    // Which requester most recently owned the RAM port.
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;

    // ARB_MODE encodings.
    localparam int unsigned ARB_D_PRIO      = 0;
    localparam int unsigned ARB_ROUND_ROBIN = 1;

    // Counter width able to hold 0..limit; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the fetch port was denied.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CNT_W = cnt_width(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // LIMIT = 0 leaves the counter at zero, so sat is permanently high.
    assign sat = (cnt_q == CNT_W'(LIMIT));

    // Next count: clear wins over increment; stop at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch (I) and load/store (D).
// Grant is combinational; read data is registered for a fixed 1-cycle response.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [3:0]        mem_byte_enable,
    output logic [31:0]       mem_write,
    input  logic [31:0]       mem_out
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } mem_req_t;

    mem_req_t   mem_req;
    arb_owner_t last_owner_q, last_owner_d;
    logic       starve_sat;
    logic       i_rvalid_q, d_rvalid_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk (clk),
        .rst (rst),
        .inc (i_req && !i_gnt),
        .clr (i_gnt || !i_req),
        .sat (starve_sat)
    );

    // Pick a winner and steer its request onto the RAM port.
    always_comb begin
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        mem_req      = '0;
        last_owner_d = last_owner_q;

        if (!rst) begin
            if (i_req && d_req) begin
                if (ARB_MODE == ARB_ROUND_ROBIN) begin
                    if (last_owner_q == OWN_I) d_gnt = 1'b1;
                    else                       i_gnt = 1'b1;
                end else if (starve_sat) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (i_req) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end

        if (i_gnt) begin
            mem_req.addr = i_addr;
            last_owner_d = OWN_I;
        end else if (d_gnt) begin
            mem_req.addr = d_addr;
            last_owner_d = OWN_D;
            if (d_we) begin
                mem_req.we    = 1'b1;
                mem_req.be    = d_be;
                mem_req.wdata = d_wdata;
            end
        end
    end

    assign mem_address     = mem_req.addr;
    assign mem_we          = mem_req.we;
    assign mem_byte_enable = mem_req.be;
    assign mem_write       = mem_req.wdata;

    // Capture the winner's response; rdata holds until that port's next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            last_owner_q <= OWN_I;
        end else begin
            i_rvalid_q   <= i_gnt;
            d_rvalid_q   <= d_gnt;
            last_owner_q <= last_owner_d;
            if (i_gnt) i_rdata_q <= mem_out;
            if (d_gnt) d_rdata_q <= d_we ? 32'h0 : mem_out;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
